// File: rtl/apb_to_ahb_bridge.sv
// ----------------------------------------------------------------------------
// apb_to_ahb_bridge
//
// Purpose: APB3 completer that turns each APB transfer into a single AHB
// NONSEQ word transfer and returns the AHB response on Pready/Prdata/Pslverr.
// AHB RETRY/SPLIT responses cause the identical transfer to be reissued, up to
// MAX_RETRY issues in total, after which the APB transfer ends with Pslverr.
//
// Ports:
//   Hclk, Hresetn        clock, asynchronous active-low reset
//   Psel/Penable/Pwrite  APB control (completer side)
//   Paddr/Pwdata         APB address / write data
//   Prdata/Pready/Pslverr APB response (registered)
//   Haddr/Htrans/Hwrite/Hsize/Hwdata  AHB master request (registered)
//   Hrdata/Hready/Hresp  AHB response from the addressed slave
// ----------------------------------------------------------------------------
module apb_to_ahb_bridge #(
  parameter int unsigned MAX_RETRY = 4
) (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic        Psel,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Pready,
  output logic        Pslverr,
  output logic [31:0] Haddr,
  output logic [1:0]  Htrans,
  output logic        Hwrite,
  output logic [2:0]  Hsize,
  output logic [31:0] Hwdata,
  input  logic [31:0] Hrdata,
  input  logic        Hready,
  input  logic [1:0]  Hresp
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  state_t      state_q;
  logic [31:0] haddr_q;
  logic [31:0] hwdata_q;
  logic [31:0] wdata_q;
  logic [31:0] prdata_q;
  logic [1:0]  htrans_q;
  logic        hwrite_q;
  logic        pready_q;
  logic        pslverr_q;
  logic        err_q;
  logic [3:0]  retry_q;

  logic [4:0]  retry_d;
  logic        retry_exhausted;
  logic        resp_done;
  logic        resp_err;
  logic        apb_access;

  // Count including the response being processed now; once it reaches
  // MAX_RETRY the transfer has been issued MAX_RETRY times and gives up.
  assign retry_d         = {1'b0, retry_q} + 5'd1;
  assign retry_exhausted = (retry_d >= 5'(MAX_RETRY));

  // Final AHB response for this APB transfer: OKAY, ERROR, or a RETRY/SPLIT
  // that used up the retry budget.
  assign resp_done  = Hready && ((Hresp == HRESP_OKAY) || (Hresp == HRESP_ERROR) || retry_exhausted);
  assign resp_err   = (Hresp != HRESP_OKAY);
  assign apb_access = Psel && Penable;

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q   <= IDLE;
      haddr_q   <= '0;
      hwdata_q  <= '0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      htrans_q  <= HTRANS_IDLE;
      hwrite_q  <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      err_q     <= 1'b0;
      retry_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          // Only an APB setup phase starts a transfer.
          if (Psel && !Penable) begin
            haddr_q  <= Paddr;
            hwrite_q <= Pwrite;
            wdata_q  <= Pwdata;
            retry_q  <= '0;
            err_q    <= 1'b0;
            htrans_q <= HTRANS_NONSEQ;
            state_q  <= ADDR;
          end
        end

        ADDR: begin
          // Address phase outputs stay put until the bus accepts them.
          if (Hready) begin
            htrans_q <= HTRANS_IDLE;
            if (hwrite_q) begin
              hwdata_q <= wdata_q;
            end
            state_q <= DATA;
          end
        end

        DATA: begin
          if (Hready) begin
            if (resp_done) begin
              if ((Hresp == HRESP_OKAY) && !hwrite_q) begin
                prdata_q <= Hrdata;
              end
              if (Hresp != HRESP_OKAY && Hresp != HRESP_ERROR) begin
                retry_q <= retry_d[3:0];
              end
              err_q     <= resp_err;
              // A requester that abandoned the access gets no completion.
              pready_q  <= apb_access;
              pslverr_q <= apb_access && resp_err;
              state_q   <= RESP;
            end else begin
              // RETRY/SPLIT with budget left: reissue the identical transfer.
              retry_q  <= retry_d[3:0];
              htrans_q <= HTRANS_NONSEQ;
              state_q  <= ADDR;
            end
          end
        end

        RESP: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          state_q   <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Prdata  = prdata_q;
  assign Pready  = pready_q;
  assign Pslverr = pslverr_q;
  assign Haddr   = haddr_q;
  assign Htrans  = htrans_q;
  assign Hwrite  = hwrite_q;
  assign Hsize   = HSIZE_WORD;
  assign Hwdata  = hwdata_q;

endmodule

// File: tb/tb_apb_to_ahb_bridge.sv
// ----------------------------------------------------------------------------
// tb_apb_to_ahb_bridge
//
// Drives APB transfers into apb_to_ahb_bridge while a small AHB slave model
// answers with configurable wait states, ERROR or RETRY responses. Expected
// APB results are queued when a transfer starts and compared when Pready
// arrives.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_apb_to_ahb_bridge;

  localparam int MAX_RETRY = 4;

  logic        Hclk = 1'b0;
  logic        Hresetn;
  logic        Psel;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic        Pready;
  logic        Pslverr;
  logic [31:0] Haddr;
  logic [1:0]  Htrans;
  logic        Hwrite;
  logic [2:0]  Hsize;
  logic [31:0] Hwdata;
  logic [31:0] Hrdata;
  logic        Hready;
  logic [1:0]  Hresp;

  always #5 Hclk = ~Hclk;

  apb_to_ahb_bridge #(.MAX_RETRY(MAX_RETRY)) dut (
    .Hclk    (Hclk),
    .Hresetn (Hresetn),
    .Psel    (Psel),
    .Penable (Penable),
    .Pwrite  (Pwrite),
    .Paddr   (Paddr),
    .Pwdata  (Pwdata),
    .Prdata  (Prdata),
    .Pready  (Pready),
    .Pslverr (Pslverr),
    .Haddr   (Haddr),
    .Htrans  (Htrans),
    .Hwrite  (Hwrite),
    .Hsize   (Hsize),
    .Hwdata  (Hwdata),
    .Hrdata  (Hrdata),
    .Hready  (Hready),
    .Hresp   (Hresp)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard entry: what the APB side must see when Pready arrives.
  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cycles;
    int          issues;
  } exp_t;

  exp_t sb_q[$];
  logic [31:0] model_prdata = 32'h0;

  // AHB slave model configuration and observation.
  int          cfg_waits   = 0;
  int          cfg_retries = 0;
  logic        cfg_err     = 1'b0;
  logic [31:0] cfg_rdata   = 32'h0;
  logic [31:0] cur_addr    = 32'h0;
  logic [31:0] cur_wdata   = 32'h0;
  logic        cur_write   = 1'b0;
  int          xfer_seq    = 0;
  int          nonseq_cnt  = 0;

  // AHB slave model: counts NONSEQ issues, checks the request, and answers.
  initial begin : ahb_slave
    int retries_done;
    int last_seq;
    retries_done = 0;
    last_seq     = -1;
    Hready = 1'b1;
    Hresp  = 2'b00;
    Hrdata = 32'h0BAD_0000;
    forever begin
      @(negedge Hclk);
      if (Hresetn && Htrans == 2'b10 && Hready) begin
        if (xfer_seq != last_seq) begin
          last_seq     = xfer_seq;
          retries_done = 0;
        end
        nonseq_cnt++;
        check_val("haddr", Haddr, cur_addr);
        check_val("hwrite", 32'(Hwrite), 32'(cur_write));
        @(posedge Hclk); #1;
        if (cur_write) check_val("hwdata", Hwdata, cur_wdata);
        if (retries_done < cfg_retries) begin
          retries_done++;
          Hready = 1'b0; Hresp = 2'b10;
          @(posedge Hclk); #1;
          Hready = 1'b1;
          @(posedge Hclk); #1;
          Hresp = 2'b00;
        end else if (cfg_err) begin
          Hready = 1'b0; Hresp = 2'b01;
          @(posedge Hclk); #1;
          Hready = 1'b1;
          @(posedge Hclk); #1;
          Hresp = 2'b00;
        end else begin
          for (int i = 0; i < cfg_waits && Hresetn; i++) begin
            Hready = 1'b0;
            @(posedge Hclk); #1;
          end
          Hready = 1'b1;
          Hrdata = cfg_rdata;
          @(posedge Hclk); #1;
          Hrdata = 32'h0BAD_0000;
        end
      end
    end
  end

  // Protocol watchers on the APB response.
  always @(negedge Hclk) begin
    if (Pslverr && !Pready) check_val("pslverr_without_pready", 32'(Pslverr), 32'h0);
    if (Pready && !(Psel && Penable)) check_val("pready_outside_access", 32'(Pready), 32'h0);
  end

  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic exp_err, input int exp_cycles, input int exp_issues);
    exp_t e;
    exp_t got;
    int   n;
    int   start_cnt;
    cur_addr  = addr;
    cur_wdata = wdata;
    cur_write = wr;
    xfer_seq++;
    if (!wr && !exp_err) model_prdata = cfg_rdata;
    e.err    = exp_err;
    e.rdata  = model_prdata;
    e.cycles = exp_cycles;
    e.issues = exp_issues;
    sb_q.push_back(e);
    start_cnt = nonseq_cnt;

    @(posedge Hclk); #1;
    Psel = 1'b1; Penable = 1'b0; Pwrite = wr; Paddr = addr; Pwdata = wdata;
    @(negedge Hclk);
    check_val("pready_in_setup", 32'(Pready), 32'h0);
    @(posedge Hclk); #1;
    Penable = 1'b1;
    n = 1;
    @(negedge Hclk);
    while (!Pready && n < 100) begin
      @(negedge Hclk);
      n++;
    end
    got = sb_q.pop_front();
    check_val("pready", 32'(Pready), 32'h1);
    check_val("latency", n, got.cycles);
    check_val("pslverr", 32'(Pslverr), 32'(got.err));
    check_val("prdata", Prdata, got.rdata);
    check_val("nonseq_issues", nonseq_cnt - start_cnt, got.issues);
    $display("xfer %s addr=0x%08h wdata=0x%08h prdata=0x%08h pslverr=%0d cycles=%0d issues=%0d",
             wr ? "WR" : "RD", addr, wdata, Prdata, Pslverr, n, nonseq_cnt - start_cnt);
    @(posedge Hclk); #1;
    Psel = 1'b0; Penable = 1'b0;
    @(negedge Hclk);
    check_val("pready_one_cycle", 32'(Pready), 32'h0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  initial begin : main
    int start_cnt;
    Hresetn = 1'b0;
    Psel = 1'b0; Penable = 1'b0; Pwrite = 1'b0; Paddr = '0; Pwdata = '0;
    repeat (2) @(negedge Hclk);
    check_val("rst_htrans", 32'(Htrans), 32'h0);
    check_val("rst_hsize", 32'(Hsize), 32'h2);
    check_val("rst_pready", 32'(Pready), 32'h0);
    check_val("rst_prdata", Prdata, 32'h0);
    Hresetn = 1'b1;

    // 1: zero-wait write
    apb_xfer(1'b1, 32'h0000_1000, 32'hA5A5_0001, 1'b0, 3, 1);

    // 2: read with two AHB wait states
    cfg_waits = 2; cfg_rdata = 32'hDEAD_BEEF;
    apb_xfer(1'b0, 32'h0000_2004, 32'h0, 1'b0, 5, 1);
    cfg_waits = 0;

    // 3: read answered with ERROR, Prdata must keep its old value
    cfg_err = 1'b1; cfg_rdata = 32'h1234_0000;
    apb_xfer(1'b0, 32'h0000_3008, 32'h0, 1'b1, 4, 1);
    cfg_err = 1'b0;

    // 4: two RETRY responses then OKAY
    cfg_retries = 2;
    apb_xfer(1'b1, 32'h0000_4000, 32'h1234_5678, 1'b0, 9, 3);

    // 5: RETRY forever, gives up after MAX_RETRY issues
    cfg_retries = 1000;
    apb_xfer(1'b1, 32'h0000_5000, 32'h5555_AAAA, 1'b1, 3 * MAX_RETRY + 1, MAX_RETRY);
    cfg_retries = 0;

    // zero-wait read right after an error completion
    cfg_rdata = 32'hCAFE_0001;
    apb_xfer(1'b0, 32'h0000_6000, 32'h0, 1'b0, 3, 1);

    // Psel dropped during ADDR: AHB transfer completes, no APB completion
    cur_addr = 32'h0000_7000; cur_write = 1'b0; cfg_rdata = 32'h7777_0000;
    xfer_seq++;
    start_cnt = nonseq_cnt;
    @(posedge Hclk); #1;
    Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b0; Paddr = cur_addr;
    @(posedge Hclk); #1;
    Psel = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Hclk);
      check_val("abandoned_pready", 32'(Pready), 32'h0);
    end
    check_val("abandoned_issues", nonseq_cnt - start_cnt, 32'h1);
    $display("xfer RD addr=0x%08h abandoned after setup", cur_addr);

    // 6: reset during DATA with Hready low
    cfg_waits = 3;
    cur_addr = 32'h0000_8000; cur_write = 1'b0;
    xfer_seq++;
    @(posedge Hclk); #1;
    Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b0; Paddr = cur_addr;
    @(posedge Hclk); #1;
    Penable = 1'b1;
    @(negedge Hclk);
    @(negedge Hclk);
    check_val("pre_rst_hready_low", 32'(Hready), 32'h0);
    Hresetn = 1'b0;
    #1;
    check_val("arst_htrans", 32'(Htrans), 32'h0);
    check_val("arst_haddr", Haddr, 32'h0);
    check_val("arst_hwrite", 32'(Hwrite), 32'h0);
    check_val("arst_hsize", 32'(Hsize), 32'h2);
    check_val("arst_hwdata", Hwdata, 32'h0);
    check_val("arst_prdata", Prdata, 32'h0);
    check_val("arst_pready", 32'(Pready), 32'h0);
    check_val("arst_pslverr", 32'(Pslverr), 32'h0);
    $display("xfer RD addr=0x%08h aborted by reset", cur_addr);
    Psel = 1'b0; Penable = 1'b0;
    repeat (3) @(negedge Hclk);
    check_val("in_rst_pready", 32'(Pready), 32'h0);
    Hresetn = 1'b1;
    model_prdata = 32'h0;
    cfg_waits = 0;
    apb_xfer(1'b1, 32'h0000_9000, 32'h0F0F_0F0F, 1'b0, 3, 1);

    repeat (2) @(negedge Hclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
